// File: rtl/register.sv
// Router packet-datapath register stage: header capture, payload/held-byte
// forwarding to the FIFO, and running XOR parity check. Optional macro:
// REGISTER_ADDR_FILTER_EN (ignore headers addressed to port 2'b11).
module register (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_valid,
  input  logic [7:0] din,
  input  logic       fifo_full,
  input  logic       detect_addr,
  input  logic       ld_state,
  input  logic       laf_state,
  input  logic       full_state,
  input  logic       lfd_state,
  input  logic       rst_int_reg,
  output logic [7:0] dout,
  output logic       err,
  output logic       parity_done,
  output logic       low_pkt_valid
);

  logic [7:0] hdr_byte;
  logic [7:0] full_byte;
  logic [7:0] int_parity;
  logic [7:0] pkt_parity;
  logic       hdr_load;

`ifdef REGISTER_ADDR_FILTER_EN
  assign hdr_load = detect_addr && pkt_valid && (din[1:0] != 2'b11);
`else
  assign hdr_load = detect_addr && pkt_valid;
`endif

  // Header and byte-forwarding path
  always_ff @(posedge clk) begin
    if (!rst) begin
      hdr_byte  <= 8'h00;
      full_byte <= 8'h00;
      dout      <= 8'h00;
    end else begin
      if (hdr_load)
        hdr_byte <= din;
      if (lfd_state)
        dout <= hdr_byte;
      else if (ld_state && !fifo_full)
        dout <= din;
      else if (ld_state && fifo_full)
        full_byte <= din;
      else if (laf_state)
        dout <= full_byte;
    end
  end

  // Running parity over header and payload; trailing byte kept separately
  always_ff @(posedge clk) begin
    if (!rst) begin
      int_parity <= 8'h00;
      pkt_parity <= 8'h00;
    end else if (detect_addr) begin
      int_parity <= 8'h00;
      pkt_parity <= 8'h00;
    end else begin
      if (lfd_state)
        int_parity <= int_parity ^ hdr_byte;
      else if (ld_state && pkt_valid && !full_state)
        int_parity <= int_parity ^ din;
      if (ld_state && !pkt_valid)
        pkt_parity <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      low_pkt_valid <= 1'b0;
    else if (rst_int_reg)
      low_pkt_valid <= 1'b0;
    else if (ld_state && !pkt_valid)
      low_pkt_valid <= 1'b1;
  end

  // err compares only after parity_done is registered, so both parity bytes are settled
  always_ff @(posedge clk) begin
    if (!rst) begin
      parity_done <= 1'b0;
      err         <= 1'b0;
    end else if (detect_addr) begin
      parity_done <= 1'b0;
      err         <= 1'b0;
    end else begin
      if ((ld_state && !fifo_full && !pkt_valid) ||
          (laf_state && low_pkt_valid && !parity_done))
        parity_done <= 1'b1;
      if (parity_done)
        err <= (int_parity != pkt_parity);
    end
  end

endmodule

// File: tb/tb_register.sv
// Directed scoreboard bench for the router register stage: the driver queues the
// expected post-edge outputs, a monitor pops and compares them after each edge.
module tb_register;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pkt_valid = 1'b0;
  logic [7:0] din = 8'h00;
  logic       fifo_full = 1'b0;
  logic       detect_addr = 1'b0;
  logic       ld_state = 1'b0;
  logic       laf_state = 1'b0;
  logic       full_state = 1'b0;
  logic       lfd_state = 1'b0;
  logic       rst_int_reg = 1'b0;
  logic [7:0] dout;
  logic       err;
  logic       parity_done;
  logic       low_pkt_valid;

  register dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .din(din),
    .fifo_full(fifo_full), .detect_addr(detect_addr), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .lfd_state(lfd_state),
    .rst_int_reg(rst_int_reg), .dout(dout), .err(err),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] dout;
    logic       err;
    logic       pd;
    logic       lpv;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   done = 1'b0;

  localparam logic [7:0] HDR = 8'h15;
  logic [7:0] payload [8] = '{8'h3C, 8'h81, 8'h5A, 8'hC3, 8'h07, 8'hF0, 8'h99, 8'h42};
  // 15^3C^81^5A^C3^07^F0^99^42 worked by hand
  localparam logic [7:0] GOOD_PAR = 8'h1D;
  localparam logic [7:0] BAD_PAR  = 8'd46;

  // Monitor: one expected record per clock edge, compared 1 time unit after it
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (dout !== e.dout) begin
        failures++;
        $display("FAIL %s dout got %h want %h", e.name, dout, e.dout);
      end
      checks++;
      if (err !== e.err) begin
        failures++;
        $display("FAIL %s err got %b want %b", e.name, err, e.err);
      end
      checks++;
      if (parity_done !== e.pd) begin
        failures++;
        $display("FAIL %s parity_done got %b want %b", e.name, parity_done, e.pd);
      end
      checks++;
      if (low_pkt_valid !== e.lpv) begin
        failures++;
        $display("FAIL %s low_pkt_valid got %b want %b", e.name, low_pkt_valid, e.lpv);
      end
    end
  end

  task automatic tick(input string name, input logic [7:0] d, input logic e,
                      input logic pd, input logic lpv);
    exp_t x;
    x.name = name; x.dout = d; x.err = e; x.pd = pd; x.lpv = lpv;
    q.push_back(x);
    @(negedge clk);
  endtask

  task automatic idle();
    pkt_valid = 1'b0; din = 8'h00; fifo_full = 1'b0; detect_addr = 1'b0;
    ld_state = 1'b0; laf_state = 1'b0; full_state = 1'b0; lfd_state = 1'b0;
    rst_int_reg = 1'b0;
  endtask

  // Header, lfd, eight payload bytes; lpv_in is low_pkt_valid carried in
  task automatic send_body(input string tag, input logic [7:0] prev_dout,
                           input logic lpv_in);
    idle(); detect_addr = 1'b1; pkt_valid = 1'b1; din = HDR;
    tick({tag, "_hdr"}, prev_dout, 1'b0, 1'b0, lpv_in);
    idle(); lfd_state = 1'b1; pkt_valid = 1'b1;
    tick({tag, "_lfd"}, HDR, 1'b0, 1'b0, lpv_in);
    for (int i = 0; i < 8; i++) begin
      idle(); ld_state = 1'b1; pkt_valid = 1'b1; din = payload[i];
      tick($sformatf("%s_pl%0d", tag, i), payload[i], 1'b0, 1'b0, lpv_in);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL timeout queue=%0d", q.size());
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    rst = 1'b0;
    tick("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    // Good packet
    send_body("good", 8'h00, 1'b0);
    idle(); ld_state = 1'b1; din = GOOD_PAR;
    tick("good_par", GOOD_PAR, 1'b0, 1'b1, 1'b1);
    idle();
    tick("good_err", GOOD_PAR, 1'b0, 1'b1, 1'b1);
    rst_int_reg = 1'b1;
    tick("rst_int", GOOD_PAR, 1'b0, 1'b1, 1'b0);

    // Bad parity
    send_body("bad", GOOD_PAR, 1'b0);
    idle(); ld_state = 1'b1; din = BAD_PAR;
    tick("bad_par", BAD_PAR, 1'b0, 1'b1, 1'b1);
    idle();
    tick("bad_err", BAD_PAR, 1'b1, 1'b1, 1'b1);
    tick("bad_hold", BAD_PAR, 1'b1, 1'b1, 1'b1);

    // FIFO full on the parity byte; detect_addr clears err/parity_done
    idle(); detect_addr = 1'b1; pkt_valid = 1'b1; din = HDR; rst_int_reg = 1'b1;
    tick("full_hdr", BAD_PAR, 1'b0, 1'b0, 1'b0);
    idle(); lfd_state = 1'b1; pkt_valid = 1'b1;
    tick("full_lfd", HDR, 1'b0, 1'b0, 1'b0);
    idle(); ld_state = 1'b1; pkt_valid = 1'b1; din = 8'h11;
    tick("full_pl", 8'h11, 1'b0, 1'b0, 1'b0);
    idle(); ld_state = 1'b1; fifo_full = 1'b1; din = 8'hA5;
    tick("full_hold", 8'h11, 1'b0, 1'b0, 1'b1);
    idle(); full_state = 1'b1; fifo_full = 1'b1;
    tick("full_stall", 8'h11, 1'b0, 1'b0, 1'b1);
    idle(); laf_state = 1'b1;
    tick("full_laf", 8'hA5, 1'b0, 1'b1, 1'b1);
    idle();
    // 15^11 = 04 versus captured A5
    tick("full_err", 8'hA5, 1'b1, 1'b1, 1'b1);

    // Header with address 2'b11
    idle(); detect_addr = 1'b1; pkt_valid = 1'b1; din = 8'h17; rst_int_reg = 1'b1;
    tick("inv_hdr", 8'hA5, 1'b0, 1'b0, 1'b0);
    idle(); lfd_state = 1'b1; pkt_valid = 1'b1;
`ifdef REGISTER_ADDR_FILTER_EN
    tick("inv_lfd", HDR, 1'b0, 1'b0, 1'b0);
`else
    tick("inv_lfd", 8'h17, 1'b0, 1'b0, 1'b0);
`endif

    // Reset mid-packet clears hdr_byte too
    idle(); ld_state = 1'b1; pkt_valid = 1'b1; din = 8'h66;
    tick("mid_pl", 8'h66, 1'b0, 1'b0, 1'b0);
    idle(); ld_state = 1'b1; din = 8'h77; rst = 1'b0;
    tick("mid_rst", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    idle(); lfd_state = 1'b1;
    tick("post_rst_lfd", 8'h00, 1'b0, 1'b0, 1'b0);

    idle();
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain queue got %0d want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
